// File: rtl/vram_ctrl.sv
// vram_ctrl -- initiator for the dual-port video DRAM bus.
//
// Turns single host requests (byte read, byte write, read transfer) into
// RAS/CAS/WE/OE strobe sequences on the random-access port, and generates
// SC pulses on the serial port. Every bus output is driven from a register.
//
// Ports
//   MCLK, RESET_n             clock (rising edge), synchronous active-low reset
//   req/req_we/req_xfer       host request and type; sampled only in IDLE
//   req_addr, req_wdata       [15:8] row, [7:0] column or serial tap; write byte
//   req_ack, busy             accept pulse; high whenever the FSM is not IDLE
//   rd_data, rd_valid         last read byte and its 1-cycle update pulse
//   ser_en, ser_req           serial output enable; start one SC pulse
//   ser_busy, ser_data,       SC pulse in progress; byte captured from SD_i
//   ser_valid                 and its 1-cycle update pulse
//   RAS, CAS, WE, OE, AD      active-low DRAM strobes, multiplexed address
//   RD_o, RD_oe, RD_i         random-port data out, drive enable, data in
//   SC, SE, SD_i              serial clock, serial enable (active low), data
module vram_ctrl #(
    parameter int unsigned T_RCD = 2,
    parameter int unsigned T_CAS = 3,
    parameter int unsigned T_RP  = 2,
    parameter int unsigned T_SC  = 2
) (
    input  logic        MCLK,
    input  logic        RESET_n,
    input  logic        req,
    input  logic        req_we,
    input  logic        req_xfer,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        req_ack,
    output logic        busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        ser_en,
    input  logic        ser_req,
    output logic        ser_busy,
    output logic [7:0]  ser_data,
    output logic        ser_valid,
    output logic        RAS,
    output logic        CAS,
    output logic        WE,
    output logic        OE,
    output logic [7:0]  AD,
    output logic [7:0]  RD_o,
    output logic        RD_oe,
    input  logic [7:0]  RD_i,
    output logic        SC,
    output logic        SE,
    input  logic [7:0]  SD_i
);

    localparam logic [3:0] RCD_M1 = 4'(T_RCD - 1);
    localparam logic [3:0] CAS_M1 = 4'(T_CAS - 1);
    localparam logic [3:0] RP_M1  = 4'(T_RP - 1);
    localparam logic [3:0] SC_M1  = 4'(T_SC - 1);

    typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_XEND, S_PRE} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  col_q;
    logic [7:0]  wdata_q;
    logic        is_wr_q;
    logic        is_xfer_q;

    logic        ras_q, cas_q, we_q, oe_q, rd_oe_q;
    logic [7:0]  ad_q, rd_o_q, rd_data_q;
    logic        req_ack_q, rd_valid_q;

    logic        sc_q, ser_busy_q, ser_pend_q, ser_valid_q, se_q;
    logic [3:0]  scnt_q;
    logic [7:0]  ser_data_q;

    logic        xend_next_d;
    logic        ser_go_d;
    logic        ser_hold_d;

    // The FSM is about to enter XEND, where OE rises. A serial start accepted
    // now would raise SC in that same cycle, so it is parked for one cycle.
    assign xend_next_d = (state_q == S_COL) && (cnt_q == 4'd0) && is_xfer_q;
    assign ser_go_d    = (ser_req | ser_pend_q) & ~ser_busy_q & ~xend_next_d;
    assign ser_hold_d  = (ser_req | ser_pend_q) & ~ser_busy_q &  xend_next_d;

    // Random-access port FSM: IDLE -> ROW -> COL -> [XEND] -> PRE -> IDLE.
    // Strobes are assigned on the edge that enters each state.
    always_ff @(posedge MCLK) begin
        if (!RESET_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            col_q      <= 8'd0;
            wdata_q    <= 8'd0;
            is_wr_q    <= 1'b0;
            is_xfer_q  <= 1'b0;
            ras_q      <= 1'b1;
            cas_q      <= 1'b1;
            we_q       <= 1'b1;
            oe_q       <= 1'b1;
            rd_oe_q    <= 1'b0;
            ad_q       <= 8'd0;
            rd_o_q     <= 8'd0;
            rd_data_q  <= 8'd0;
            req_ack_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            req_ack_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        state_q   <= S_ROW;
                        cnt_q     <= RCD_M1;
                        col_q     <= req_addr[7:0];
                        wdata_q   <= req_wdata;
                        is_xfer_q <= req_xfer;
                        is_wr_q   <= req_we & ~req_xfer;
                        req_ack_q <= 1'b1;
                        ras_q     <= 1'b0;
                        ad_q      <= req_addr[15:8];
                        // OE low while RAS falls latches a transfer cycle
                        oe_q      <= ~req_xfer;
                    end
                end
                S_ROW: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_COL;
                        cnt_q   <= CAS_M1;
                        cas_q   <= 1'b0;
                        ad_q    <= col_q;
                        oe_q    <= is_wr_q;
                        we_q    <= ~is_wr_q;
                        rd_oe_q <= is_wr_q;
                        rd_o_q  <= wdata_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_COL: begin
                    if (cnt_q == 4'd0) begin
                        if (is_xfer_q) begin
                            // Rising OE with RAS/CAS still low loads the serial register
                            state_q <= S_XEND;
                            oe_q    <= 1'b1;
                        end else begin
                            state_q <= S_PRE;
                            cnt_q   <= RP_M1;
                            ras_q   <= 1'b1;
                            cas_q   <= 1'b1;
                            we_q    <= 1'b1;
                            oe_q    <= 1'b1;
                            rd_oe_q <= 1'b0;
                            if (!is_wr_q) begin
                                rd_data_q  <= RD_i;
                                rd_valid_q <= 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_XEND: begin
                    state_q <= S_PRE;
                    cnt_q   <= RP_M1;
                    ras_q   <= 1'b1;
                    cas_q   <= 1'b1;
                    we_q    <= 1'b1;
                    oe_q    <= 1'b1;
                    rd_oe_q <= 1'b0;
                end
                S_PRE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Serial port: T_SC cycles SC high, T_SC cycles SC low per pulse.
    always_ff @(posedge MCLK) begin
        if (!RESET_n) begin
            sc_q        <= 1'b0;
            ser_busy_q  <= 1'b0;
            ser_pend_q  <= 1'b0;
            scnt_q      <= 4'd0;
            ser_data_q  <= 8'd0;
            ser_valid_q <= 1'b0;
            se_q        <= 1'b1;
        end else begin
            se_q        <= ~ser_en;
            ser_valid_q <= 1'b0;
            ser_pend_q  <= ser_hold_d;
            if (ser_go_d) begin
                sc_q       <= 1'b1;
                ser_busy_q <= 1'b1;
                scnt_q     <= SC_M1;
            end else if (ser_busy_q) begin
                if (scnt_q != 4'd0) begin
                    scnt_q <= scnt_q - 4'd1;
                end else if (sc_q) begin
                    // Last SC-high cycle: the VRAM output is settled
                    sc_q        <= 1'b0;
                    scnt_q      <= SC_M1;
                    ser_data_q  <= SD_i;
                    ser_valid_q <= 1'b1;
                end else begin
                    ser_busy_q <= 1'b0;
                end
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign req_ack   = req_ack_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign ser_busy  = ser_busy_q;
    assign ser_data  = ser_data_q;
    assign ser_valid = ser_valid_q;
    assign RAS       = ras_q;
    assign CAS       = cas_q;
    assign WE        = we_q;
    assign OE        = oe_q;
    assign AD        = ad_q;
    assign RD_o      = rd_o_q;
    assign RD_oe     = rd_oe_q;
    assign SC        = sc_q;
    assign SE        = se_q;

endmodule

// File: tb/tb_vram_ctrl.sv
// Testbench for vram_ctrl with a behavioural dual-port VRAM attached.
// Memory starts with mem[a] = a[15:8] + a[7:0].
module tb_vram_ctrl;

    logic        MCLK = 1'b0;
    logic        RESET_n;
    logic        req, req_we, req_xfer;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_ack, busy, rd_valid;
    logic [7:0]  rd_data;
    logic        ser_en, ser_req, ser_busy, ser_valid;
    logic [7:0]  ser_data;
    logic        RAS, CAS, WE, OE, RD_oe, SC, SE;
    logic [7:0]  AD, RD_o, RD_i, SD_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 MCLK = ~MCLK;

    vram_ctrl dut (
        .MCLK(MCLK), .RESET_n(RESET_n),
        .req(req), .req_we(req_we), .req_xfer(req_xfer),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .busy(busy), .rd_data(rd_data), .rd_valid(rd_valid),
        .ser_en(ser_en), .ser_req(ser_req), .ser_busy(ser_busy),
        .ser_data(ser_data), .ser_valid(ser_valid),
        .RAS(RAS), .CAS(CAS), .WE(WE), .OE(OE), .AD(AD),
        .RD_o(RD_o), .RD_oe(RD_oe), .RD_i(RD_i),
        .SC(SC), .SE(SE), .SD_i(SD_i)
    );

    // Behavioural VRAM
    logic [7:0] mem  [0:65535];
    logic [7:0] sreg [0:255];
    logic [7:0] m_row = 8'd0, m_col = 8'd0, m_tap = 8'd0;
    logic       m_dt = 1'b0;
    logic       p_ras = 1'b1, p_cas = 1'b1, p_oe = 1'b1, p_sc = 1'b0;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] av;
            av = 16'(a);
            mem[a] <= av[15:8] + av[7:0];
        end
    end

    always @(negedge MCLK) begin
        if (p_ras && !RAS) begin
            m_row <= AD;
            m_dt  <= !OE;
        end
        if (p_cas && !CAS) begin
            m_col <= AD;
            if (!WE && RD_oe) mem[{m_row, AD}] <= RD_o;
        end
        if (!p_oe && OE && !RAS && m_dt) begin
            for (int i = 0; i < 256; i++) sreg[i] <= mem[{m_row, 8'(i)}];
            m_tap <= m_col;
        end
        if (p_sc && !SC) m_tap <= m_tap + 8'd1;
        p_ras <= RAS;
        p_cas <= CAS;
        p_oe  <= OE;
        p_sc  <= SC;
    end

    assign RD_i = (!OE && !CAS) ? mem[{m_row, m_col}] : 8'h00;
    assign SD_i = sreg[m_tap];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance into the next cycle (inputs driven at +1), then sample at negedge
    task automatic step_drive;
        @(posedge MCLK);
        #1;
    endtask

    task automatic sample;
        @(negedge MCLK);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy && k < 40) begin
            step_drive();
            sample();
            k++;
        end
        chk(nm, busy, 1'b0);
    endtask

    task automatic ser_pulse(input string nm, input logic [7:0] exp);
        int  k;
        logic seen;
        step_drive();
        ser_req = 1'b1;
        step_drive();
        ser_req = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            sample();
            if (ser_valid) seen = 1'b1;
            else step_drive();
            k++;
        end
        chk({nm, "_valid"}, seen, 1'b1);
        chk({nm, "_data"}, ser_data, exp);
        k = 0;
        while (ser_busy && k < 20) begin
            step_drive();
            sample();
            k++;
        end
        chk({nm, "_idle"}, ser_busy, 1'b0);
    endtask

    typedef struct {
        logic       req;
        logic [6:0] ctl;     // {req_ack, busy, RAS, CAS, WE, OE, rd_valid}
        logic       ad_chk;
        logic [7:0] ad;
    } vec_t;

    vec_t rd_tbl [0:8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acks [$];
        int   k;
        logic seen;

        // Read of row 0x12 column 0x34, cycle 0 = request cycle
        rd_tbl[0] = '{1'b1, 7'b0011110, 1'b0, 8'h00};
        rd_tbl[1] = '{1'b0, 7'b1101110, 1'b1, 8'h12};
        rd_tbl[2] = '{1'b0, 7'b0101110, 1'b1, 8'h12};
        rd_tbl[3] = '{1'b0, 7'b0100100, 1'b1, 8'h34};
        rd_tbl[4] = '{1'b0, 7'b0100100, 1'b1, 8'h34};
        rd_tbl[5] = '{1'b0, 7'b0100100, 1'b1, 8'h34};
        rd_tbl[6] = '{1'b0, 7'b0111111, 1'b0, 8'h00};
        rd_tbl[7] = '{1'b0, 7'b0111110, 1'b0, 8'h00};
        rd_tbl[8] = '{1'b0, 7'b0011110, 1'b0, 8'h00};

        RESET_n = 1'b0; req = 1'b0; req_we = 1'b0; req_xfer = 1'b0;
        req_addr = 16'h0; req_wdata = 8'h0; ser_en = 1'b0; ser_req = 1'b0;
        repeat (3) step_drive();
        sample();
        chk("rst_ctl", {RAS, CAS, WE, OE, SC, SE, RD_oe, req_ack, rd_valid, ser_valid, ser_busy, busy},
            12'b111101000000);
        chk("rst_data", {AD, RD_o, rd_data, ser_data}, 32'h0);
        step_drive();
        RESET_n = 1'b1;
        step_drive();

        // Table-driven read
        req_addr = 16'h1234;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step_drive();
            req = rd_tbl[i].req;
            sample();
            chk($sformatf("rd_ctl_c%0d", i), {req_ack, busy, RAS, CAS, WE, OE, rd_valid}, rd_tbl[i].ctl);
            if (rd_tbl[i].ad_chk) chk($sformatf("rd_ad_c%0d", i), AD, rd_tbl[i].ad);
            if (i == 6) chk("rd_data_c6", rd_data, 8'h46);
        end

        // Write 0xA5 to 0x1234, then read it back
        step_drive();
        req = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
        for (int c = 1; c <= 8; c++) begin
            step_drive();
            req = 1'b0;
            sample();
            chk($sformatf("wr_we_c%0d", c), WE, !(c >= 3 && c <= 5));
            chk($sformatf("wr_oe_c%0d", c), RD_oe, (c >= 3 && c <= 5));
            if (c >= 3 && c <= 5) chk($sformatf("wr_rdo_c%0d", c), RD_o, 8'hA5);
        end
        chk("wr_done_busy", busy, 1'b0);
        step_drive();
        req = 1'b1; req_we = 1'b0;
        step_drive();
        req = 1'b0;
        seen = 1'b0; k = 0;
        while (!seen && k < 20) begin
            sample();
            if (rd_valid) seen = 1'b1;
            else step_drive();
            k++;
        end
        chk("rb_valid", seen, 1'b1);
        chk("rb_data", rd_data, 8'hA5);
        wait_idle("rb_idle");

        // Read transfer row 0x40 tap 0x10 (req_we also set: xfer wins),
        // serial request in the last COL cycle, another while busy
        ser_en = 1'b1;
        step_drive();
        req = 1'b1; req_xfer = 1'b1; req_we = 1'b1; req_addr = 16'h4010;
        for (int c = 1; c <= 12; c++) begin
            step_drive();
            req = 1'b0;
            ser_req = (c == 5) || (c == 8);
            sample();
            case (c)
                1: chk("xf_c1_ras_oe", {RAS, OE}, 2'b00);
                5: chk("xf_c5_cas_oe", {CAS, OE, WE}, 3'b001);
                6: chk("xf_c6_xend", {RAS, CAS, WE, OE, SC}, 5'b00110);
                7: chk("xf_c7_sc", {SC, ser_busy, RAS}, 3'b111);
                8: chk("xf_c8_sc", SC, 1'b1);
                9: begin
                    chk("xf_c9_sc", {SC, ser_valid}, 2'b01);
                    chk("xf_c9_data", ser_data, 8'h50);
                end
                10: chk("xf_c10", {SC, ser_busy}, 2'b01);
                11: chk("xf_c11", {SC, ser_busy, busy}, 3'b000);
                12: chk("xf_c12_nopulse", {SC, ser_busy}, 2'b00);
                default: ;
            endcase
        end
        ser_req = 1'b0; req_xfer = 1'b0; req_we = 1'b0;
        chk("se_low", SE, 1'b0);
        ser_pulse("ser2", 8'h51);
        ser_pulse("ser3", 8'h52);

        // Back-to-back reads with req held high
        step_drive();
        req = 1'b1; req_addr = 16'h0000;
        for (int c = 1; c <= 26; c++) begin
            step_drive();
            if (c == 26) req = 1'b0;
            sample();
            if (req_ack) acks.push_back(c);
            if (c == 6 || c == 7 || c == 14 || c == 15)
                chk($sformatf("b2b_pre_c%0d", c), RAS, 1'b1);
        end
        chk("b2b_count", acks.size(), 4);
        for (int i = 0; i < acks.size() && i < 4; i++)
            chk($sformatf("b2b_ack%0d", i), acks[i], 1 + 8 * i);
        wait_idle("b2b_idle");

        // Reset asserted during COL of a write
        step_drive();
        req = 1'b1; req_we = 1'b1; req_addr = 16'h2222; req_wdata = 8'h3C;
        for (int c = 1; c <= 9; c++) begin
            step_drive();
            req = 1'b0;
            if (c == 4) RESET_n = 1'b0;
            if (c == 5) RESET_n = 1'b1;
            sample();
            if (c == 3) chk("rstw_c3_we", {WE, CAS, RD_oe}, 3'b001);
            if (c == 5) chk("rstw_c5", {RAS, CAS, WE, OE, RD_oe, busy}, 6'b111100);
            if (c >= 5) chk($sformatf("rstw_rdv_c%0d", c), rd_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
